// File: rtl/cursor_overlay.sv
// Blinking crosshair overlay on a VGA pixel stream; position sampled once per frame and clamped to the screen.
// Latency: fixed 2 cycles for RGB_Out, Pixel_Valid_Out and Frame_Start_Out.
// Backpressure: none; one pixel accepted every clock and Pixel_Valid gaps pass through unchanged.
//
// Ports:
//   Clock, Reset (async, active-high)
//   X_Position, Y_Position  : cursor position from the cursor stage (Y counts up the screen)
//   Cursor_Enable, Blink_Enable : cursor draw / blink controls
//   Frame_Start, Pixel_Valid, Pixel_X, Pixel_Y, RGB_In : pixel stream from the timing generator
//   Pixel_Valid_Out, Frame_Start_Out, RGB_Out          : delayed, composited stream to the DAC
module cursor_overlay #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          COORD_W      = 10,
    parameter int          COLOR_W      = 12,
    parameter int          ARM_LEN      = 8,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] CURSOR_COLOR = 12'hFFF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [COORD_W-1:0] X_Position,
    input  logic [COORD_W-1:0] Y_Position,
    input  logic               Cursor_Enable,
    input  logic               Blink_Enable,
    input  logic               Frame_Start,
    input  logic               Pixel_Valid,
    input  logic [COORD_W-1:0] Pixel_X,
    input  logic [COORD_W-1:0] Pixel_Y,
    input  logic [COLOR_W-1:0] RGB_In,
    output logic               Pixel_Valid_Out,
    output logic               Frame_Start_Out,
    output logic [COLOR_W-1:0] RGB_Out
);

    localparam int DW    = COORD_W + 1;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [DW-1:0]      ARM       = DW'(ARM_LEN);
    localparam logic [COLOR_W-1:0] CUR_COLOR = COLOR_W'(CURSOR_COLOR);

    // ------------------------------------------------------------------
    // Per-frame state: latched position, arm flag, blink counter/phase
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] cx_q, cx_d;
    logic [COORD_W-1:0] cy_q, cy_d;
    logic               armed_q, armed_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               phase_on_q, phase_on_d;
    logic [COORD_W-1:0] ry;

    always_comb begin
        cx_d        = cx_q;
        cy_d        = cy_q;
        armed_d     = armed_q;
        blink_cnt_d = blink_cnt_q;
        phase_on_d  = phase_on_q;
        // Clamp rather than wrap: a cursor counter that underflowed past 0
        // shows up as a large value and must pin to the far edge.
        ry = (Y_Position >= Y_MAX) ? Y_MAX : Y_Position;

        if (Frame_Start) begin
            cx_d    = (X_Position >= X_MAX) ? X_MAX : X_Position;
            cy_d    = Y_MAX - ry;   // cursor Y grows upward, screen rows grow downward
            armed_d = 1'b1;
        end

        if (!Blink_Enable) begin
            blink_cnt_d = '0;
            phase_on_d  = 1'b1;
        end else if (Frame_Start) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                phase_on_d  = ~phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cx_q        <= '0;
            cy_q        <= '0;
            armed_q     <= 1'b0;
            blink_cnt_q <= '0;
            phase_on_q  <= 1'b1;
        end else begin
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            armed_q     <= armed_d;
            blink_cnt_q <= blink_cnt_d;
            phase_on_q  <= phase_on_d;
        end
    end

    // ------------------------------------------------------------------
    // Hit test against the position held in the registers. On a
    // Frame_Start cycle the registers still hold the previous frame's
    // position, so a coincident pixel naturally uses the old cursor.
    // One extra bit keeps the differences signed without wrap, so arms
    // clip at screen edges instead of reappearing on the far side.
    // ------------------------------------------------------------------
    logic signed [DW-1:0] dx, dy;
    logic        [DW-1:0] adx, ady;
    logic                 x_eq, y_eq, x_near, y_near, draw_en;

    always_comb begin
        dx      = $signed({1'b0, Pixel_X}) - $signed({1'b0, cx_q});
        dy      = $signed({1'b0, Pixel_Y}) - $signed({1'b0, cy_q});
        adx     = dx[DW-1] ? DW'(-dx) : DW'(dx);
        ady     = dy[DW-1] ? DW'(-dy) : DW'(dy);
        x_eq    = (Pixel_X == cx_q);
        y_eq    = (Pixel_Y == cy_q);
        x_near  = (adx <= ARM);
        y_near  = (ady <= ARM);
        // Gating is captured with the pixel so each pixel sees a coherent
        // arm/blink/enable state regardless of what changes a cycle later.
        draw_en = armed_q && phase_on_q && Cursor_Enable;
    end

    // ------------------------------------------------------------------
    // Stage 1
    // ------------------------------------------------------------------
    logic               s1_vld_q, s1_fs_q;
    logic [COLOR_W-1:0] s1_rgb_q;
    logic               s1_xeq_q, s1_yeq_q, s1_xnear_q, s1_ynear_q, s1_draw_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1_vld_q   <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_rgb_q   <= '0;
            s1_xeq_q   <= 1'b0;
            s1_yeq_q   <= 1'b0;
            s1_xnear_q <= 1'b0;
            s1_ynear_q <= 1'b0;
            s1_draw_q  <= 1'b0;
        end else begin
            s1_vld_q   <= Pixel_Valid;
            s1_fs_q    <= Frame_Start;
            s1_rgb_q   <= RGB_In;
            s1_xeq_q   <= x_eq;
            s1_yeq_q   <= y_eq;
            s1_xnear_q <= x_near;
            s1_ynear_q <= y_near;
            s1_draw_q  <= draw_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: composite and drive the DAC
    // ------------------------------------------------------------------
    logic               hit;
    logic [COLOR_W-1:0] rgb_d;
    logic               out_vld_q, out_fs_q;
    logic [COLOR_W-1:0] out_rgb_q;

    always_comb begin
        hit   = (s1_yeq_q && s1_xnear_q) || (s1_xeq_q && s1_ynear_q);
        rgb_d = s1_rgb_q;
        if (!s1_vld_q) begin
            rgb_d = '0;
        end else if (hit && s1_draw_q) begin
            rgb_d = CUR_COLOR;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            out_vld_q <= 1'b0;
            out_fs_q  <= 1'b0;
            out_rgb_q <= '0;
        end else begin
            out_vld_q <= s1_vld_q;
            out_fs_q  <= s1_fs_q;
            out_rgb_q <= rgb_d;
        end
    end

    assign Pixel_Valid_Out = out_vld_q;
    assign Frame_Start_Out = out_fs_q;
    assign RGB_Out         = out_rgb_q;

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay: hand-computed expected colours per pixel.
// Each pixel is driven for one cycle and its output sampled 2 cycles later.
// No backpressure exists, so every wait is a fixed cycle count.
module tb_cursor_overlay;

    localparam int CW  = 10;
    localparam int CLW = 12;
    localparam logic [11:0] CUR = 12'hFFF;
    localparam logic [11:0] BG  = 12'h0F0;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [CW-1:0]  X_Position, Y_Position, Pixel_X, Pixel_Y;
    logic           Cursor_Enable, Blink_Enable, Frame_Start, Pixel_Valid;
    logic [CLW-1:0] RGB_In;
    logic           Pixel_Valid_Out, Frame_Start_Out;
    logic [CLW-1:0] RGB_Out;

    int n_chk  = 0;
    int n_pass = 0;

    cursor_overlay #(
        .H_ACTIVE(640), .V_ACTIVE(480), .COORD_W(CW), .COLOR_W(CLW),
        .ARM_LEN(8), .BLINK_FRAMES(2), .CURSOR_COLOR(12'hFFF)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .X_Position     (X_Position),
        .Y_Position     (Y_Position),
        .Cursor_Enable  (Cursor_Enable),
        .Blink_Enable   (Blink_Enable),
        .Frame_Start    (Frame_Start),
        .Pixel_Valid    (Pixel_Valid),
        .Pixel_X        (Pixel_X),
        .Pixel_Y        (Pixel_Y),
        .RGB_In         (RGB_In),
        .Pixel_Valid_Out(Pixel_Valid_Out),
        .Frame_Start_Out(Frame_Start_Out),
        .RGB_Out        (RGB_Out)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        Pixel_Valid = 1'b0;
        Frame_Start = 1'b0;
        Pixel_X     = '0;
        Pixel_Y     = '0;
        RGB_In      = '0;
    endtask

    // Drive one pixel (optionally with Frame_Start), then check it 2 cycles later.
    task automatic px(input string tag, input logic v, input logic fs,
                      input int x, input int y, input logic [11:0] rgb,
                      input logic [11:0] exp);
        Pixel_Valid = v;
        Frame_Start = fs;
        Pixel_X     = CW'(x);
        Pixel_Y     = CW'(y);
        RGB_In      = rgb;
        @(posedge Clock); #1;
        idle();
        @(posedge Clock); #1;
        chk(tag, {20'd0, RGB_Out}, {20'd0, exp});
        chk({tag, "_vld"}, {31'd0, Pixel_Valid_Out}, {31'd0, v});
        chk({tag, "_fs"}, {31'd0, Frame_Start_Out}, {31'd0, fs});
    endtask

    // Frame_Start pulse during blanking (no valid pixel).
    task automatic frame();
        px("frame", 1'b0, 1'b1, 0, 0, 12'h000, 12'h000);
    endtask

    bit exp_on [6] = '{1, 1, 0, 0, 1, 1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1;
        idle();
        X_Position    = '0;
        Y_Position    = '0;
        Cursor_Enable = 1'b1;
        Blink_Enable  = 1'b0;
        #12;
        chk("rst_rgb", {20'd0, RGB_Out}, 32'd0);
        chk("rst_vld", {31'd0, Pixel_Valid_Out}, 32'd0);
        chk("rst_fs",  {31'd0, Frame_Start_Out}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // 1: not armed until first Frame_Start. Y=379 puts screen row at 100.
        X_Position = 10'd100;
        Y_Position = 10'd379;
        px("t1_unarmed", 1'b1, 1'b0, 100, 100, BG, BG);
        frame();
        px("t1_armed",   1'b1, 1'b0, 100, 100, BG, CUR);
        Cursor_Enable = 1'b0;
        px("t1_cen0",    1'b1, 1'b0, 100, 100, BG, BG);
        Cursor_Enable = 1'b1;

        // 2: centre (320,239), arm ends inclusive, one past excluded
        X_Position = 10'd320;
        Y_Position = 10'd240;
        frame();
        px("t2_left",   1'b1, 1'b0, 312, 239, BG, CUR);
        px("t2_right",  1'b1, 1'b0, 328, 239, BG, CUR);
        px("t2_top",    1'b1, 1'b0, 320, 231, BG, CUR);
        px("t2_bot",    1'b1, 1'b0, 320, 247, BG, CUR);
        px("t2_left9",  1'b1, 1'b0, 311, 239, BG, BG);
        px("t2_top9",   1'b1, 1'b0, 320, 230, BG, BG);
        px("t2_diag",   1'b1, 1'b0, 321, 240, BG, BG);
        px("t2_gap",    1'b0, 1'b0, 320, 239, BG, 12'h000);

        // 3: X wrapped to 1023 clamps to 639; Y=0 is bottom row 479
        X_Position = 10'd1023;
        Y_Position = 10'd0;
        frame();
        px("t3_631",    1'b1, 1'b0, 631, 479, BG, CUR);
        px("t3_639",    1'b1, 1'b0, 639, 479, BG, CUR);
        px("t3_up",     1'b1, 1'b0, 639, 471, BG, CUR);
        px("t3_nowrap", 1'b1, 1'b0, 0,   479, BG, BG);
        px("t3_630",    1'b1, 1'b0, 630, 479, BG, BG);

        // 3b: Y beyond top clamps to row 0; left arm clipped at column 0
        X_Position = 10'd0;
        Y_Position = 10'd1023;
        frame();
        px("t3b_r8",    1'b1, 1'b0, 8,   0, BG, CUR);
        px("t3b_d8",    1'b1, 1'b0, 0,   8, BG, CUR);
        px("t3b_far",   1'b1, 1'b0, 639, 0, BG, BG);

        // 5: position sampled only on Frame_Start
        X_Position = 10'd200;
        Y_Position = 10'd240;
        frame();
        px("t5_200",     1'b1, 1'b0, 200, 244, BG, CUR);
        X_Position = 10'd201;
        px("t5_hold",    1'b1, 1'b0, 200, 244, BG, CUR);
        px("t5_201pre",  1'b1, 1'b0, 201, 244, BG, BG);
        px("t5_coinc",   1'b1, 1'b1, 201, 244, BG, BG);
        px("t5_201post", 1'b1, 1'b0, 201, 244, BG, CUR);
        px("t5_200post", 1'b1, 1'b0, 200, 244, BG, BG);

        // 4: blink with BLINK_FRAMES=2 -> ON,ON,OFF,OFF,ON,ON
        X_Position = 10'd320;
        Y_Position = 10'd240;
        frame();
        Blink_Enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) frame();
            px($sformatf("t4_f%0d", i), 1'b1, 1'b0, 320, 239, BG, exp_on[i] ? CUR : BG);
        end
        frame();
        px("t4_f6", 1'b1, 1'b0, 320, 239, BG, BG);
        Blink_Enable = 1'b0;
        frame();
        px("t4_off_on", 1'b1, 1'b0, 320, 239, BG, CUR);

        // 6: reset mid-line clears outputs at once and disarms
        Pixel_Valid = 1'b1; Pixel_X = 10'd320; Pixel_Y = 10'd239; RGB_In = BG;
        @(posedge Clock); #1;
        Pixel_X = 10'd321;
        @(posedge Clock); #1;
        chk("t6_pre_rgb", {20'd0, RGB_Out}, {20'd0, CUR});
        chk("t6_pre_vld", {31'd0, Pixel_Valid_Out}, 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("t6_rst_rgb", {20'd0, RGB_Out}, 32'd0);
        chk("t6_rst_vld", {31'd0, Pixel_Valid_Out}, 32'd0);
        Reset = 1'b0;
        idle();
        @(posedge Clock); #1;
        px("t6_unarmed", 1'b1, 1'b0, 320, 239, BG, BG);
        frame();
        px("t6_rearmed", 1'b1, 1'b0, 320, 239, BG, CUR);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
